// File: rtl/alu_control_md.sv
// alu_control_md: registered ALU control decoder with a multi-cycle mult/div sequencer and HI/LO hazard stall.
module alu_control_md #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] Op,
  output logic       op_valid,
  output logic       illegal,
  output logic       hilo_rd,
  output logic       hilo_sel,
  output logic       md_start,
  output logic [1:0] md_op,
  output logic       md_busy,
  output logic       md_done,
  output logic       stall_req
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_dec;
  logic             op_valid_q, illegal_q, hilo_rd_q, hilo_sel_q, md_start_q, md_done_q;
  logic [1:0]       md_op_q;
  logic             ill_dec, hrd_dec, hsel_dec, md_dec, hilo_hz, accept, start;
  always_comb begin
    op_dec   = 4'b0010;
    ill_dec  = 1'b0;
    hrd_dec  = 1'b0;
    hsel_dec = 1'b0;
    md_dec   = 1'b0;
    case (ALUOp)
      2'b01: op_dec = 4'b0110;
      2'b11: op_dec = 4'b0111;
      2'b10:
        case (funct)
          6'd32, 6'd33:               op_dec = 4'b0010;
          6'd34, 6'd35:               op_dec = 4'b0110;
          6'd36:                      op_dec = 4'b0000;
          6'd37:                      op_dec = 4'b0001;
          6'd38:                      op_dec = 4'b0011;
          6'd39:                      op_dec = 4'b1100;
          6'd42:                      op_dec = 4'b0111;
          6'd43:                      op_dec = 4'b1000;
          6'd16:                      begin hrd_dec = 1'b1; hsel_dec = 1'b1; end
          6'd18:                      hrd_dec = 1'b1;
          6'd24, 6'd25, 6'd26, 6'd27: md_dec = 1'b1;
          default:                    begin op_dec = 4'b1111; ill_dec = 1'b1; end
        endcase
      default: op_dec = 4'b0010;
    endcase
  end
  // Anything that touches HI/LO must wait while a mult/div is still running.
  assign hilo_hz   = (ALUOp == 2'b10) && (funct == 6'd16 || funct == 6'd18 || funct[5:2] == 4'b0110);
  assign stall_req = valid_in && hilo_hz && (state_q == RUN);
  assign accept    = valid_in && !stall_req;
  assign start     = accept && md_dec;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = RUN;
      cnt_d   = CNT_W'(MD_CYCLES - 1);
    end else if (state_q == RUN) begin
      state_d = (cnt_q == '0) ? DONE : RUN;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= 4'b0000;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      hilo_rd_q  <= 1'b0;
      hilo_sel_q <= 1'b0;
      md_start_q <= 1'b0;
      md_done_q  <= 1'b0;
      md_op_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_valid_q <= accept;
      hilo_rd_q  <= accept && hrd_dec;
      md_start_q <= start;
      md_done_q  <= (state_q == RUN) && (cnt_q == '0);
      if (accept) begin
        op_q       <= op_dec;
        illegal_q  <= ill_dec;
        hilo_sel_q <= hsel_dec;
      end
      if (start) md_op_q <= funct[1:0];
    end
  end
  assign Op       = op_q;
  assign op_valid = op_valid_q;
  assign illegal  = illegal_q;
  assign hilo_rd  = hilo_rd_q;
  assign hilo_sel = hilo_sel_q;
  assign md_start = md_start_q;
  assign md_op    = md_op_q;
  assign md_busy  = (state_q == RUN);
  assign md_done  = md_done_q;
endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md: directed plus randomized checks of alu_control_md against a cycle-timestamp reference model.
module tb_alu_control_md;
  localparam int MD = 4;
  logic       clk = 1'b0, rst_n = 1'b1, valid_in = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [5:0] funct = 6'd0;
  logic [3:0] Op;
  logic       op_valid, illegal, hilo_rd, hilo_sel, md_start, md_busy, md_done, stall_req;
  logic [1:0] md_op;
  int         checks = 0, failures = 0, cyc = 0, ls = -100;
  logic [3:0] e_op = 4'b0000;
  logic       e_ill = 1'b0, e_hsel = 1'b0;
  logic [1:0] e_mdop = 2'b00;
  int         op_tbl[64];
  int         picks[16] = '{16, 18, 24, 25, 26, 27, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  int         sweep[11] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 5};

  alu_control_md #(.MD_CYCLES(MD), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALUOp(ALUOp), .funct(funct),
    .Op(Op), .op_valid(op_valid), .illegal(illegal), .hilo_rd(hilo_rd), .hilo_sel(hilo_sel),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
    end
  endtask

  // The model tracks only the cycle index at which md_start was seen (ls);
  // RUN spans ls..ls+MD-1 and the done pulse lands at ls+MD.
  function automatic bit in_run(input int c);
    return c >= ls && c < ls + MD;
  endfunction

  task automatic check_outputs(input bit acc, input bit hrd);
    chk("op_valid", 8'(op_valid), 8'(acc));
    chk("Op", 8'(Op), 8'(e_op));
    chk("illegal", 8'(illegal), 8'(e_ill));
    chk("hilo_sel", 8'(hilo_sel), 8'(e_hsel));
    if (acc) chk("hilo_rd", 8'(hilo_rd), 8'(hrd));
    chk("md_start", 8'(md_start), 8'(cyc == ls));
    chk("md_busy", 8'(md_busy), 8'(in_run(cyc)));
    chk("md_done", 8'(md_done), 8'(cyc == ls + MD));
    chk("md_op", 8'(md_op), 8'(e_mdop));
  endtask

  task automatic step(input bit v, input logic [1:0] a, input logic [5:0] f);
    bit hz, st, acc, md, hrd;
    @(negedge clk);
    valid_in = v; ALUOp = a; funct = f;
    #1;
    hz = (a == 2'b10) && (f == 6'd16 || f == 6'd18 || (f >= 6'd24 && f <= 6'd27));
    st = v && hz && in_run(cyc);
    chk("stall_req", 8'(stall_req), 8'(st));
    acc = v && !st;
    md  = acc && (a == 2'b10) && f >= 6'd24 && f <= 6'd27;
    hrd = acc && (a == 2'b10) && (f == 6'd16 || f == 6'd18);
    if (acc) begin
      e_op   = (a == 2'b10) ? 4'(op_tbl[f]) : (a == 2'b00) ? 4'd2 : (a == 2'b01) ? 4'd6 : 4'd7;
      e_ill  = (a == 2'b10) && op_tbl[f] == 15;
      e_hsel = (a == 2'b10) && f == 6'd16;
    end
    if (md) begin
      ls     = cyc + 1;
      e_mdop = f[1:0];
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs(acc, hrd);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0; valid_in = 1'b0;
    #1;
    ls = -100; e_op = 4'b0000; e_ill = 1'b0; e_hsel = 1'b0; e_mdop = 2'b00;
    check_outputs(1'b0, 1'b0);
    repeat (hold) begin @(posedge clk); cyc++; end
    #1;
    check_outputs(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) op_tbl[i] = 15;
    op_tbl[32] = 2; op_tbl[33] = 2; op_tbl[34] = 6; op_tbl[35] = 6; op_tbl[36] = 0;
    op_tbl[37] = 1; op_tbl[38] = 3; op_tbl[39] = 12; op_tbl[42] = 7; op_tbl[43] = 8;
    op_tbl[16] = 2; op_tbl[18] = 2; op_tbl[24] = 2; op_tbl[25] = 2; op_tbl[26] = 2; op_tbl[27] = 2;
    do_reset(2);
    step(1, 2'b00, 6'd0); step(1, 2'b01, 6'd0); step(1, 2'b11, 6'd0);
    step(1, 2'b10, 6'd39);
    do_reset(1);
    step(0, 2'b10, 6'd32);
    for (int i = 0; i < 11; i++) step(1, 2'b10, 6'(sweep[i]));
    step(1, 2'b10, 6'd24);
    step(1, 2'b10, 6'd32);
    repeat (4) step(1, 2'b10, 6'd18);
    repeat (2) step(0, 2'b00, 6'd0);
    step(1, 2'b10, 6'd24);
    repeat (4) step(0, 2'b00, 6'd0);
    step(1, 2'b10, 6'd27);
    step(1, 2'b10, 6'd24);
    step(1, 2'b10, 6'd16);
    repeat (4) step(0, 2'b00, 6'd0);
    step(1, 2'b10, 6'd16);
    step(1, 2'b10, 6'd24);
    step(0, 2'b00, 6'd0);
    do_reset(1);
    repeat (2) step(0, 2'b00, 6'd0);
    step(1, 2'b10, 6'd25);
    repeat (7) step(0, 2'b00, 6'd0);
    for (int i = 0; i < 400; i++) begin
      logic [1:0] a;
      logic [5:0] f;
      a = ($urandom % 2 == 0) ? 2'b10 : 2'($urandom % 4);
      f = ($urandom % 4 != 0) ? 6'(picks[$urandom % 16]) : 6'($urandom % 64);
      if ($urandom % 100 == 0) do_reset(1);
      else step($urandom % 4 != 0, a, f);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
